// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CHK,
        DONE,
        ERROR
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;
    localparam int WORD_W         = BYTES_PER_WORD * 8;
    localparam int LEN_W          = LEN_BYTES * 8;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    // States in which the stream handshake is open.
    function automatic logic accepts_byte(input state_e s);
        return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CHK);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian stream bytes into 32-bit words; emits a one-cycle
// word_valid pulse with the registered word after the fourth byte.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_xfer,
    input  logic [7:0]        i_byte,
    output logic              o_last_byte,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word
);

    logic [IDX_W-1:0]  r_byte_idx;
    logic [WORD_W-9:0] r_shift;
    logic [WORD_W-1:0] r_word;
    logic              r_word_valid;

    assign o_last_byte  = (r_byte_idx == IDX_W'(BYTES_PER_WORD - 1));
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_idx   <= '0;
            r_shift      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_byte_idx <= '0;
                r_shift    <= '0;
            end else if (i_xfer) begin
                if (o_last_byte) begin
                    // Earlier bytes already sit LS-first in the shift register.
                    r_word       <= {i_byte, r_shift};
                    r_word_valid <= 1'b1;
                    r_byte_idx   <= '0;
                end else begin
                    r_shift    <= {i_byte, r_shift[WORD_W-9:8]};
                    r_byte_idx <= r_byte_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory program loader: length-prefixed byte stream to IM writes.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int MAX_WORDS = (1 << ADDR_W) - BASE_ADDR;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e ST_TAIL = CHK;
`else
    localparam state_e ST_TAIL = DONE;
`endif

    state_e            r_state;
    state_e            w_next;
    logic              r_in_ready;
    logic [7:0]        r_len_lo;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_im_addr;
    logic [ADDR_W:0]   r_words;

    logic              w_xfer;
    logic              w_start_ok;
    logic              w_asm_xfer;
    logic              w_last_byte;
    logic              w_last_word;
    logic              w_len_ovf;
    logic [LEN_W-1:0]  w_len_in;
    logic              w_word_valid;
    logic [WORD_W-1:0] w_word;

    assign w_xfer      = in_valid && r_in_ready;
    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
    assign w_asm_xfer  = w_xfer && (r_state == DATA);
    assign w_len_in    = {in_data, r_len_lo};
    assign w_len_ovf   = 32'(w_len_in) > 32'(MAX_WORDS);
    assign w_last_word = (32'(r_words) + 32'd1) == 32'(r_len);

    word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start_ok),
        .i_xfer       (w_asm_xfer),
        .i_byte       (in_data),
        .o_last_byte  (w_last_byte),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum <= '0;
        end else if (w_start_ok) begin
            r_csum <= '0;
        end else if (w_asm_xfer) begin
            r_csum <= r_csum ^ in_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERROR: if (start) w_next = LEN0;
            LEN0:              if (w_xfer) w_next = LEN1;
            LEN1: begin
                if (w_xfer) begin
                    if (w_len_ovf)            w_next = ERROR;
                    else if (w_len_in == '0)  w_next = ST_TAIL;
                    else                      w_next = DATA;
                end
            end
            DATA:              if (w_asm_xfer && w_last_byte && w_last_word) w_next = ST_TAIL;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:               if (w_xfer) w_next = (in_data == r_csum) ? DONE : ERROR;
`endif
            default:           w_next = IDLE;
        endcase
    end

    always_comb begin
        cpu_hold = (r_state != DONE);
        done     = (r_state == DONE);
        err      = (r_state == ERROR);
    end

    // Write address is latched with the 4th byte so im_addr holds between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b0;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_addr     <= ADDR_W'(BASE_ADDR);
            r_im_addr  <= ADDR_W'(BASE_ADDR);
            r_words    <= '0;
        end else begin
            r_in_ready <= accepts_byte(w_next);
            if (w_start_ok) begin
                r_addr  <= ADDR_W'(BASE_ADDR);
                r_words <= '0;
            end else if (w_xfer) begin
                if (r_state == LEN0) r_len_lo <= in_data;
                if (r_state == LEN1) r_len    <= w_len_in;
                if ((r_state == DATA) && w_last_byte) begin
                    r_im_addr <= r_addr;
                    r_addr    <= r_addr + ADDR_W'(1);
                    r_words   <= r_words + (ADDR_W + 1)'(1);
                end
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign im_we        = w_word_valid;
    assign im_addr      = r_im_addr;
    assign im_wdata     = w_word;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader; builds frames from word lists and
// predicts writes and final status from the frame rules.
module tb_imem_loader;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int BASE_ADDR = 0;
    localparam int MAX_WORDS = (1 << ADDR_W) - BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] frame_words[$];
    int          n_checks    = 0;
    int          n_errors    = 0;
    int          spacing_bad = 0;
    longint      cyc         = 0;
    longint      last_we     = -100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Capture every IM write and track spacing between strobes.
    always @(negedge clk) begin
        if (im_we) begin
            wr_q.push_back('{addr: im_addr, data: im_wdata});
            if (cyc - last_we < 4) spacing_bad++;
            last_we = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_im_we"}, im_we, 0);
        check({tag, "_im_addr"}, im_addr, BASE_ADDR);
        check({tag, "_im_wdata"}, im_wdata, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_words_loaded"}, words_loaded, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        bit   acc;
        logic rdy;
        in_valid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            rdy = in_ready;
            @(posedge clk);
            acc = rdy;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("byte_accepted", acc, 1);
    endtask

    // Sends one frame built from frame_words and checks the predicted outcome.
    task automatic run_frame(input int n, input bit do_start, input bit bad_csum,
                             input int max_gap, input string tag);
        logic [7:0]  x;
        logic [31:0] w;
        logic [31:0] nn;
        bit          ovf;
        bit          exp_err;
        int          n_exp;
        x  = 8'h00;
        nn = n;
        wr_q.delete();
        if (do_start) pulse_start();
        send_byte(nn[7:0], max_gap);
        send_byte(nn[15:8], max_gap);
        ovf = (n > MAX_WORDS);
        if (!ovf) begin
            for (int i = 0; i < n; i++) begin
                w = frame_words[i];
                for (int b = 0; b < 4; b++) begin
                    x = x ^ w[8*b +: 8];
                    send_byte(w[8*b +: 8], max_gap);
                end
            end
            if (CSUM_EN) send_byte(bad_csum ? (x ^ 8'h01) : x, max_gap);
        end
        repeat (6) @(negedge clk);
        exp_err = ovf || (CSUM_EN && bad_csum);
        n_exp   = ovf ? 0 : n;
        check({tag, "_nwrites"}, wr_q.size(), n_exp);
        for (int i = 0; i < wr_q.size() && i < n_exp; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, BASE_ADDR + i);
            check($sformatf("%s_data%0d", tag, i), wr_q[i].data, frame_words[i]);
        end
        check({tag, "_done"}, done, !exp_err);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_cpu_hold"}, cpu_hold, exp_err);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_words_loaded"}, words_loaded, n_exp);
        check({tag, "_we_spacing"}, spacing_bad, 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Two-word program, stream held valid.
        frame_words = '{32'h0000_0013, 32'h0010_0093};
        run_frame(2, 1'b1, 1'b0, 0, "basic");

        // Re-arm from DONE with an empty image.
        @(negedge clk) start = 1'b1;
        check("rearm_hold_before", cpu_hold, 0);
        @(negedge clk) start = 1'b0;
        check("rearm_hold_after", cpu_hold, 1);
        check("rearm_done_cleared", done, 0);
        frame_words.delete();
        run_frame(0, 1'b0, 1'b0, 0, "empty");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Same program with a corrupted checksum byte.
        frame_words = '{32'h0000_0013, 32'h0010_0093};
        run_frame(2, 1'b1, 1'b1, 0, "badcsum");
`endif

        // Oversized image is rejected right after the length bytes.
        frame_words.delete();
        run_frame(32'h0401, 1'b1, 1'b0, 0, "ovf");

        // Random words with random valid gaps; also restarts from ERROR.
        frame_words.delete();
        for (int i = 0; i < 3; i++) frame_words.push_back($urandom);
        run_frame(3, 1'b1, 1'b0, 5, "gaps");

        // Reset after six data bytes of a four-word image.
        frame_words.delete();
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
        @(negedge clk) rst = 1'b1;
        #1;
        check_reset("midreset");
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        frame_words.push_back($urandom);
        run_frame(1, 1'b1, 1'b0, 2, "postreset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
